cpu_hazard_scoreboard: RTL
==========================

// Module: cpu_hazard_scoreboard
// PURPOSE
//  Tracks destination registers of in-flight long-latency ops (loads, mul/div, FPU) from issue to writeback.
//  Stalls decode while any used source (rs1/rs2/rs3) waits on a result that cannot yet be bypassed.
//  The bypass path covers results already on the execute/memory/writeback buses; this block covers the rest.
//  Sits beside decode: issue side fed by decode, completion side fed by writeback.
// PARAMETERS
//  REG_COUNT  64  architectural registers tracked (int + FP, 6-bit index)
//  REG_W      6   register index width; REG_COUNT == 2**REG_W
//  CNT_W      2   per-register pending counter width; max in flight per reg = 2**CNT_W-1
// PORTS
//  i_clock           in   1      clock, rising edge
//  i_reset_n         in   1      asynchronous, active-low reset
//  i_flush           in   1      pipeline flush; discards all tracked in-flight ops
//  i_issue_valid     in   1      decode presents an instruction
//  i_issue_long      in   1      instruction result not bypassable before writeback
//  i_issue_rd        in   REG_W  destination register index
//  i_issue_rd_en     in   1      instruction writes i_issue_rd
//  i_rs1/i_rs2/i_rs3 in   REG_W  source register indices
//  i_rs1_en/_rs2_en/_rs3_en in 1 source actually read
//  i_complete_valid  in   1      writeback retires a long op this cycle
//  i_complete_rd     in   REG_W  register being written back
//  o_stall           out  1      hold decode; instruction NOT accepted this cycle
//  o_busy            out  1      at least one register has nonzero pending count
// BEHAVIOUR
//  - State: cnt[r], CNT_W bits per register. Reset: all cnt=0; o_stall=0, o_busy=0.
//  - Register 0 is never tracked: issue/complete to rd=0 ignored; source index 0 never stalls.
//  - pend(r) = cnt[r] - (i_complete_valid && i_complete_rd==r); a count of 1 completing this cycle is treated
//    as free (writeback bypass supplies it), i.e. no stall, same cycle.
//  - o_stall (combinational, same cycle) = i_issue_valid && !i_flush && ( any enabled rsN with pend(rsN)!=0
//    || (i_issue_rd_en && i_issue_long && rd!=0 && cnt[rd]==2**CNT_W-1) ).  Last term = saturation guard.
//  - accept = i_issue_valid && !o_stall && !i_flush && i_issue_rd_en && i_issue_long && rd!=0.
//  - Clock edge, per r: inc = accept && rd==r; dec = i_complete_valid && i_complete_rd==r && cnt[r]!=0.
//    inc&&dec -> unchanged; inc -> +1; dec -> -1. Completion on cnt==0 ignored (no underflow).
//  - Short (non-long) writers never touch cnt; their hazards are resolved by the bypass path.
//  - WAW: a second long write to a pending rd is allowed (count increments) until saturation.
//  - i_flush: all cnt cleared next edge, overrides same-cycle issue/complete; o_stall forced 0 while high.
//    Completions arriving after flush for discarded ops hit cnt==0 and are ignored.
//  - Async reset mid-operation: counts cleared immediately, stall drops without waiting for a clock.
//  - o_busy = OR of all cnt!=0 (registered state only, excludes this cycle's inputs).
//  - Issue handshake: decode holds all issue inputs stable while o_stall=1; accept happens the cycle o_stall=0.
// CONFIGURATION
//  CPU_SCOREBOARD_STATS_EN defined: adds o_stall_cycles [31:0] out, counts cycles with o_stall=1,
//    wraps at 2**32, cleared by reset only (not by flush).
//  Not defined: port absent, no counter logic; all other behaviour identical.
// TESTING
//  1. Reset, issue long rd=5, next cycle issue rs1=5 en -> o_stall=1 until cycle of complete rd=5, then 0 same cycle.
//  2. Issue long rd=0 then rs2=0 reader -> cnt unchanged, o_stall=0, o_busy=0.
//  3. Three long issues to rd=7 (CNT_W=2) -> cnt=3; fourth long rd=7 -> o_stall=1; one completion -> accepted, cnt stays 3.
//  4. Same-cycle accept rd=9 and complete rd=9 with cnt=1 -> cnt stays 1, o_busy=1.
//  5. cnt[3]=2, assert i_flush with issue -> o_stall=0, all cnt=0 next edge; later complete rd=3 -> cnt stays 0.
//  6. Deassert i_reset_n asynchronously between edges with o_stall=1 -> o_stall, o_busy =0 before next edge;
//     with CPU_SCOREBOARD_STATS_EN, o_stall_cycles=0 after reset and equals stall cycle count in scenario 1.

Source files
------------

// File: rtl/cpu_hazard_scoreboard.sv
// Decode-side hazard scoreboard: per-register pending counters for in-flight long-latency results.
// Optional CPU_SCOREBOARD_STATS_EN adds o_stall_cycles, a free-running count of stalled cycles.
module cpu_hazard_scoreboard #(
    parameter int REG_COUNT = 64,
    parameter int REG_W     = 6,
    parameter int CNT_W     = 2
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_flush,
    input  logic             i_issue_valid,
    input  logic             i_issue_long,
    input  logic [REG_W-1:0] i_issue_rd,
    input  logic             i_issue_rd_en,
    input  logic [REG_W-1:0] i_rs1,
    input  logic [REG_W-1:0] i_rs2,
    input  logic [REG_W-1:0] i_rs3,
    input  logic             i_rs1_en,
    input  logic             i_rs2_en,
    input  logic             i_rs3_en,
    input  logic             i_complete_valid,
    input  logic [REG_W-1:0] i_complete_rd,
    output logic             o_stall,
    output logic             o_busy
`ifdef CPU_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]      o_stall_cycles
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt [REG_COUNT];
    logic             src_hazard;
    logic             sat_hazard;
    logic             accept;

    // A single outstanding write that retires this cycle is covered by the writeback bypass.
    function automatic logic src_pending(input logic en, input logic [REG_W-1:0] rs,
                                         input logic [CNT_W-1:0] c, input logic completing);
        return en && (rs != '0) && (c != '0) && !((c == CNT_ONE) && completing);
    endfunction

    always_comb begin
        src_hazard = src_pending(i_rs1_en, i_rs1, cnt[i_rs1],
                                 i_complete_valid && (i_complete_rd == i_rs1))
                   | src_pending(i_rs2_en, i_rs2, cnt[i_rs2],
                                 i_complete_valid && (i_complete_rd == i_rs2))
                   | src_pending(i_rs3_en, i_rs3, cnt[i_rs3],
                                 i_complete_valid && (i_complete_rd == i_rs3));
        sat_hazard = i_issue_rd_en && i_issue_long && (i_issue_rd != '0)
                   && (cnt[i_issue_rd] == CNT_MAX);
        o_stall    = i_issue_valid && !i_flush && (src_hazard || sat_hazard);
        accept     = i_issue_valid && !o_stall && !i_flush && i_issue_rd_en
                   && i_issue_long && (i_issue_rd != '0);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int unsigned r = 0; r < REG_COUNT; r++) cnt[r] <= '0;
        end else if (i_flush) begin
            for (int unsigned r = 0; r < REG_COUNT; r++) cnt[r] <= '0;
        end else begin
            for (int unsigned r = 1; r < REG_COUNT; r++) begin
                if (accept && (i_issue_rd == REG_W'(r))) begin
                    if (!(i_complete_valid && (i_complete_rd == REG_W'(r)) && (cnt[r] != '0)))
                        cnt[r] <= cnt[r] + CNT_ONE;
                end else if (i_complete_valid && (i_complete_rd == REG_W'(r)) && (cnt[r] != '0)) begin
                    cnt[r] <= cnt[r] - CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        o_busy = 1'b0;
        for (int unsigned r = 0; r < REG_COUNT; r++) o_busy = o_busy | (cnt[r] != '0);
    end

`ifdef CPU_SCOREBOARD_STATS_EN
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)   o_stall_cycles <= '0;
        else if (o_stall) o_stall_cycles <= o_stall_cycles + 32'd1;
    end
`endif

endmodule
